// File: rtl/btn_debounce_if.sv
// Button bus between the input synchroniser, the debouncer and the counter control logic.
// The debouncer uses the slave view; the upstream/downstream side uses the master view.
interface btn_debounce_if #(
  parameter int DIGITS = 6
);
  logic [DIGITS-1:0] btn_in;
  logic [DIGITS-1:0] btn_level;
  logic [DIGITS-1:0] btn_press;
  logic [DIGITS-1:0] btn_release;
  logic [DIGITS-1:0] btn_repeat;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/btn_debounce.sv
// Per-channel debouncer producing a clean level plus press, release and auto-repeat pulses.
//   state    | meaning
//   S_IDLE   | button released, no repeat pending
//   S_DELAY  | held, counting towards the first repeat pulse
//   S_REPEAT | held, emitting repeat pulses every REPEAT_RATE cycles
module btn_debounce #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_RATE     = 100
) (
  input  logic                clk,
  input  logic                reset_n,
  btn_debounce_if.slave       bus
);

  localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [DIGITS-1:0] w_level;
  logic [DIGITS-1:0] w_press;
  logic [DIGITS-1:0] w_release;
  logic [DIGITS-1:0] w_repeat;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_ch
    logic [DBW-1:0] r_db_cnt;
    logic           r_level;
    logic           r_press;
    logic           r_release;
    logic           w_diff;
    logic           w_done;
    logic           w_rise;
    logic           w_fall;

    assign w_diff = bus.btn_in[gi] ^ r_level;
    assign w_done = w_diff && (r_db_cnt == DB_LAST);
    assign w_rise = w_done && bus.btn_in[gi];
    assign w_fall = w_done && !bus.btn_in[gi];

    // A single matching sample restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_rise;
        r_release <= w_fall;
        if (!w_diff || w_done) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
        if (w_done) begin
          r_level <= bus.btn_in[gi];
        end
      end
    end

    assign w_level[gi]   = r_level;
    assign w_press[gi]   = r_press;
    assign w_release[gi] = r_release;

    if (REPEAT_EN) begin : g_rep
      state_t         r_state;
      state_t         w_state_nxt;
      logic [RCW-1:0] r_cnt;
      logic [RCW-1:0] w_cnt_nxt;
      logic           r_repeat;
      logic           w_repeat_nxt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_repeat <= 1'b0;
        end else begin
          r_state  <= w_state_nxt;
          r_cnt    <= w_cnt_nxt;
          r_repeat <= w_repeat_nxt;
        end
      end

      // Entering DELAY on the same edge that raises the level aligns the
      // first repeat exactly REPEAT_DELAY cycles after the press pulse.
      always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_repeat_nxt = 1'b0;
        case (r_state)
          S_IDLE: begin
            w_cnt_nxt = '0;
            if (w_rise) begin
              w_state_nxt = S_DELAY;
            end
          end
          S_DELAY: begin
            if (r_cnt == RD_LAST) begin
              w_repeat_nxt = 1'b1;
              w_cnt_nxt    = '0;
              w_state_nxt  = S_REPEAT;
            end else begin
              w_cnt_nxt = r_cnt + RCW'(1);
            end
          end
          S_REPEAT: begin
            if (r_cnt == RR_LAST) begin
              w_repeat_nxt = 1'b1;
              w_cnt_nxt    = '0;
            end else begin
              w_cnt_nxt = r_cnt + RCW'(1);
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        endcase
        if (w_fall) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_repeat_nxt = 1'b0;
        end
      end

      assign w_repeat[gi] = r_repeat;
    end else begin : g_norep
      assign w_repeat[gi] = 1'b0;
    end
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_repeat  = w_repeat;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: vector tables for debounce/press/release,
// hand sequences for repeat timing, release boundary and mid-count reset.
module tb_btn_debounce;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;

  btn_debounce_if #(.DIGITS(6)) bus ();

  btn_debounce #(
    .DIGITS(6),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_EN(1'b1),
    .REPEAT_DELAY(10),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] in;
    logic [5:0] lvl;
    logic [5:0] prs;
    logic [5:0] rel;
    logic [5:0] rpt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic [5:0] l, input logic [5:0] p,
                         input logic [5:0] r, input logic [5:0] t);
    chk({nm, ".level"},   bus.btn_level,   l);
    chk({nm, ".press"},   bus.btn_press,   p);
    chk({nm, ".release"}, bus.btn_release, r);
    chk({nm, ".repeat"},  bus.btn_repeat,  t);
  endtask

  // Drive at a falling edge, advance through one rising edge, stop at the next falling edge.
  task automatic tick(input logic [5:0] v);
    bus.btn_in = v;
    @(negedge clk);
  endtask

  task automatic add(input logic [5:0] i, input logic [5:0] l, input logic [5:0] p,
                     input logic [5:0] r, input logic [5:0] t);
    vec_t v;
    v.in = i; v.lvl = l; v.prs = p; v.rel = r; v.rpt = t;
    vq.push_back(v);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      tick(vq[i].in);
      chk_all($sformatf("%s[%0d]", tag, i), vq[i].lvl, vq[i].prs, vq[i].rel, vq[i].rpt);
    end
    vq.delete();
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    bus.btn_in = 6'h3F;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 6'h00, 6'h00, 6'h00, 6'h00);
    reset_n = 1'b1;

    // Power-up press on all channels, release, then a bouncy press on btn 0.
    add(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h3F, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h3F, 6'h3F, 6'h3F, 6'h00, 6'h00);
    add(6'h3F, 6'h3F, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h3F, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h3F, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h3F, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h00, 6'h00, 6'h3F, 6'h00);
    add(6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h01, 6'h01, 6'h01, 6'h00, 6'h00);
    add(6'h01, 6'h01, 6'h00, 6'h00, 6'h00);
    run_table("t12");

    // Now in cycle P+1 (P = press cycle of btn 0); hold and check repeat schedule.
    for (int k = 2; k <= 20; k++) begin
      tick(6'h01);
      chk_all($sformatf("hold[P+%0d]", k), 6'h01, 6'h00, 6'h00,
              (k == 10 || k == 13 || k == 16 || k == 19) ? 6'h01 : 6'h00);
    end
    for (int k = 21; k <= 30; k++) begin
      tick(6'h00);
      chk_all($sformatf("drop[P+%0d]", k), (k < 24) ? 6'h01 : 6'h00, 6'h00,
              (k == 24) ? 6'h01 : 6'h00, (k == 22) ? 6'h01 : 6'h00);
    end

    // Release landing on a would-be repeat slot: the repeat must be suppressed.
    for (int k = 1; k <= 4; k++) begin
      tick(6'h01);
      chk_all($sformatf("repress[%0d]", k), (k == 4) ? 6'h01 : 6'h00,
              (k == 4) ? 6'h01 : 6'h00, 6'h00, 6'h00);
    end
    for (int k = 1; k <= 25; k++) begin
      tick((k <= 12) ? 6'h01 : 6'h00);
      chk_all($sformatf("relb[Q+%0d]", k), (k < 16) ? 6'h01 : 6'h00, 6'h00,
              (k == 16) ? 6'h01 : 6'h00, (k == 10 || k == 13) ? 6'h01 : 6'h00);
    end

    // btn 1 and btn 4 together, only btn 4 bounces.
    add(6'h12, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h02, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h12, 6'h00, 6'h00, 6'h00, 6'h00);
    add(6'h12, 6'h02, 6'h02, 6'h00, 6'h00);
    add(6'h12, 6'h02, 6'h00, 6'h00, 6'h00);
    add(6'h12, 6'h12, 6'h10, 6'h00, 6'h00);
    add(6'h12, 6'h12, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h12, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h12, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h12, 6'h00, 6'h00, 6'h00);
    add(6'h00, 6'h00, 6'h00, 6'h12, 6'h00);
    add(6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
    run_table("t5");

    // Reset while btn 2 is held and btn 0 sits at db_cnt==3.
    for (int k = 0; k < 4; k++) tick(6'h04);
    chk_all("pre_rst_hold", 6'h04, 6'h04, 6'h00, 6'h00);
    for (int k = 0; k < 3; k++) tick(6'h05);
    chk_all("pre_rst_cnt", 6'h04, 6'h00, 6'h00, 6'h00);
    bus.btn_in = 6'h05;
    #2 reset_n = 1'b0;
    #1 chk_all("async_rst", 6'h00, 6'h00, 6'h00, 6'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(6'h05);
      chk_all($sformatf("post_rst[%0d]", k), (k >= 4) ? 6'h05 : 6'h00,
              (k == 4) ? 6'h05 : 6'h00, 6'h00, 6'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
